// File: rtl/sockit_cdc_ser_if.sv
// Wide-word input handshake plus narrow beat output handshake for sockit_cdc_ser.
// Latency: none (signal bundle only).
// Backpressure: sri_req/sri_grt on the word side, cdi_req/cdi_grt on the beat side.
interface sockit_cdc_ser_if #(
    parameter int DW = 8,
    parameter int BN = 4
);
    localparam int LW = $clog2(BN);

    logic [BN*DW-1:0] sri_dat;
    logic [LW-1:0]    sri_bcn;
    logic             sri_req;
    logic             sri_grt;
    logic [DW-1:0]    cdi_dat;
    logic             cdi_req;
    logic             cdi_grt;

    // The serializer side: consumes words, produces beats.
    modport slave (
        input  sri_dat, sri_bcn, sri_req, cdi_grt,
        output sri_grt, cdi_dat, cdi_req
    );

    // The surrounding logic: produces words, consumes beats.
    modport master (
        output sri_dat, sri_bcn, sri_req, cdi_grt,
        input  sri_grt, cdi_dat, cdi_req
    );
endinterface

// File: rtl/sockit_cdc_ser.sv
// Serializes BN*DW-bit words (with per-word beat count) into DW-bit beats for the CDC input.
// Latency: 1 cycle from accepted word to first beat request; n beats take n cycles at full grant.
// Backpressure: beats hold while cdi_grt is low; sri_grt rises only on the final granted beat or when idle.
module sockit_cdc_ser #(
    parameter int DW = 8,
    parameter int BN = 4,
    parameter int BE = 0
) (
    input  logic                  cdi_clk,
    input  logic                  cdi_rst,
    input  logic                  i_cdi_clr,
    sockit_cdc_ser_if.slave       io_bus,
    output logic [15:0]           o_sts_cnt
);
    localparam int LW = $clog2(BN);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BN*DW-1:0] r_hld;
    logic [BN*DW-1:0] w_hld_nxt;
    logic [BN*DW-1:0] w_hld_shf;
    logic [LW-1:0]    r_rem;
    logic [LW-1:0]    w_rem_nxt;
    logic [15:0]      r_cnt;
    logic [15:0]      w_cnt_nxt;
    logic             w_act;
    logic             w_last;
    logic             w_sri_grt;
    logic             w_sri_trn;
    logic             w_cdi_trn;

    assign w_act  = (r_state == ST_SHIFT);
    assign w_last = (r_rem == '0);

    // Grant is combinational from cdi_grt so a new word loads on the last beat without a bubble.
    assign w_sri_grt = ~i_cdi_clr & (~w_act | (io_bus.cdi_grt & w_last));
    assign w_sri_trn = io_bus.sri_req & w_sri_grt;
    assign w_cdi_trn = w_act & io_bus.cdi_grt;

    // Shift toward the output slice; vacated beats fill with zero.
    assign w_hld_shf = (BE != 0) ? (r_hld << DW) : (r_hld >> DW);

    assign io_bus.sri_grt = w_sri_grt;
    assign io_bus.cdi_req = w_act;
    assign io_bus.cdi_dat = (BE != 0) ? r_hld[BN*DW-1 -: DW] : r_hld[DW-1:0];
    assign o_sts_cnt      = r_cnt;

    // Next-state and datapath update; clear wins over any transfer, a new word wins over the shift.
    always_comb begin
        w_state_nxt = r_state;
        w_hld_nxt   = r_hld;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        if (i_cdi_clr) begin
            w_state_nxt = ST_IDLE;
            w_hld_nxt   = '0;
            w_rem_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            if (w_cdi_trn) begin
                if (w_last) begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rem_nxt = r_rem - LW'(1);
                    w_hld_nxt = w_hld_shf;
                end
            end
            if (w_sri_trn) begin
                w_state_nxt = ST_SHIFT;
                w_hld_nxt   = io_bus.sri_dat;
                w_rem_nxt   = io_bus.sri_bcn;
            end
        end
    end

    // State and datapath registers; reset drops any held word immediately.
    always_ff @(posedge cdi_clk or posedge cdi_rst) begin
        if (cdi_rst) begin
            r_state <= ST_IDLE;
            r_hld   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hld   <= w_hld_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule
